// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the two-requester DRAM request arbiter.
package dram_arb_pkg;

    localparam int LEN_W           = 4;
    localparam int ADDR_W          = 32;
    localparam int DATA_W          = 32;
    localparam int STRB_W          = 4;
    localparam int ID_W            = 4;
    localparam int TIMEOUT_DEFAULT = 1023;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] SIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RDATA,
        ST_WDATA,
        ST_BRESP
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer holds the last-served requester.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd_en,
    input  logic       upd_idx,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic last_q, last_d;

    always_comb begin
        last_d = upd_en ? upd_idx : last_q;
    end

    // Reset to 1 so requester 0 wins the first contested arbitration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_q <= 1'b1;
        else      last_q <= last_d;
    end

    assign gnt_valid = |req;
    assign gnt_idx   = (req == 2'b11) ? ~last_q : req[1];

endmodule

// File: rtl/dram_req_arbiter.sv
// Arbitrates instruction/data requesters onto one AXI-style DRAM port,
// one transaction outstanding at a time, with timeout and length checking.
module dram_req_arbiter
    import dram_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    input  logic [1:0]             req_write,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][LEN_W-1:0]  req_len,
    output logic [1:0]             req_ready,
    input  logic [1:0][DATA_W-1:0] wdata,
    input  logic [1:0][STRB_W-1:0] wstrb,
    input  logic [1:0]             wvalid,
    output logic [1:0]             wready,
    output logic [DATA_W-1:0]      rdata,
    output logic [1:0]             rvalid,
    output logic                   rlast,
    output logic [1:0]             bdone,
    output logic                   err,
    output logic [ID_W-1:0]        m_arid,
    output logic [ADDR_W-1:0]      m_araddr,
    output logic [LEN_W-1:0]       m_arlen,
    output logic [2:0]             m_arsize,
    output logic [1:0]             m_arburst,
    output logic                   m_arvalid,
    input  logic                   m_arready,
    output logic [ID_W-1:0]        m_awid,
    output logic [ADDR_W-1:0]      m_awaddr,
    output logic [LEN_W-1:0]       m_awlen,
    output logic [2:0]             m_awsize,
    output logic [1:0]             m_awburst,
    output logic                   m_awvalid,
    input  logic                   m_awready,
    output logic [DATA_W-1:0]      m_wdata,
    output logic [STRB_W-1:0]      m_wstrb,
    output logic                   m_wlast,
    output logic                   m_wvalid,
    input  logic                   m_wready,
    input  logic [DATA_W-1:0]      m_rdata,
    input  logic                   m_rlast,
    input  logic                   m_rvalid,
    output logic                   m_rready,
    input  logic                   m_bvalid,
    output logic                   m_bready
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LIMIT       = TMO_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_ALIGN_MASK = ~ADDR_W'(3);

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_q, err_d;
    logic              ptr_upd;
    logic              arb_valid, arb_idx;
    logic              in_addr, in_r, in_w, in_b, any_hs;
    logic [1:0]        gnt_oh;

    rr_arb2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .upd_en    (ptr_upd),
        .upd_idx   (gnt_q),
        .gnt_valid (arb_valid),
        .gnt_idx   (arb_idx)
    );

    assign in_addr = (state_q == ST_ADDR);
    assign in_r    = (state_q == ST_RDATA);
    assign in_w    = (state_q == ST_WDATA);
    assign in_b    = (state_q == ST_BRESP);
    assign gnt_oh  = gnt_q ? 2'b10 : 2'b01;

    // Gating with rst keeps the combinational grant quiet while reset is held.
    assign req_ready = (rst && state_q == ST_IDLE && arb_valid) ? (arb_idx ? 2'b10 : 2'b01) : 2'b00;

    assign m_arvalid = in_addr & ~write_q;
    assign m_arid    = m_arvalid ? {{(ID_W-1){1'b0}}, gnt_q} : '0;
    assign m_araddr  = m_arvalid ? addr_q : '0;
    assign m_arlen   = m_arvalid ? len_q : '0;
    assign m_arsize  = m_arvalid ? SIZE_WORD : 3'd0;
    assign m_arburst = m_arvalid ? BURST_INCR : 2'b00;

    assign m_awvalid = in_addr & write_q;
    assign m_awid    = m_awvalid ? {{(ID_W-1){1'b0}}, gnt_q} : '0;
    assign m_awaddr  = m_awvalid ? addr_q : '0;
    assign m_awlen   = m_awvalid ? len_q : '0;
    assign m_awsize  = m_awvalid ? SIZE_WORD : 3'd0;
    assign m_awburst = m_awvalid ? BURST_INCR : 2'b00;

    assign m_rready = in_r;
    assign rvalid   = (in_r & m_rvalid) ? gnt_oh : 2'b00;
    assign rdata    = in_r ? m_rdata : '0;
    assign rlast    = in_r & m_rvalid & m_rlast;

    assign m_wvalid = in_w & wvalid[gnt_q];
    assign wready   = (in_w & m_wready) ? gnt_oh : 2'b00;
    assign m_wdata  = in_w ? wdata[gnt_q] : '0;
    assign m_wstrb  = in_w ? wstrb[gnt_q] : '0;
    assign m_wlast  = in_w & (beat_q == len_q);

    assign m_bready = in_b;
    assign bdone    = (in_b & m_bvalid) ? gnt_oh : 2'b00;
    assign err      = err_q;

    assign any_hs = (m_arvalid & m_arready) | (m_awvalid & m_awready) |
                    (m_wvalid & m_wready) | (in_r & m_rvalid) | (in_b & m_bvalid);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        len_d   = len_q;
        beat_d  = beat_q;
        tmo_d   = tmo_q;
        err_d   = 1'b0;
        ptr_upd = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    gnt_d   = arb_idx;
                    write_d = req_write[arb_idx];
                    addr_d  = req_addr[arb_idx] & ADDR_ALIGN_MASK;
                    len_d   = req_len[arb_idx];
                    beat_d  = '0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if ((m_arvalid && m_arready) || (m_awvalid && m_awready))
                    state_d = write_q ? ST_WDATA : ST_RDATA;
            end
            ST_RDATA: begin
                if (m_rvalid) begin
                    // Saturate so a runaway burst never wraps back to a matching count.
                    beat_d = (beat_q == '1) ? beat_q : beat_q + 1'b1;
                    if (m_rlast) begin
                        state_d = ST_IDLE;
                        ptr_upd = 1'b1;
                        beat_d  = '0;
                        err_d   = (beat_q != len_q);
                    end else begin
                        err_d = (beat_q == len_q);
                    end
                end
            end
            ST_WDATA: begin
                if (m_wvalid && m_wready) begin
                    if (m_wlast) begin
                        state_d = ST_BRESP;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_BRESP: begin
                if (m_bvalid) begin
                    state_d = ST_IDLE;
                    ptr_upd = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Watchdog overrides whatever the channel logic decided.
        if (state_q == ST_IDLE || any_hs) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LIMIT) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            ptr_upd = 1'b1;
            tmo_d   = '0;
            beat_d  = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dram_req_arbiter.sv
// Directed bench: stimulus pushes expected channel events, a negedge monitor pops and compares.
module tb_dram_req_arbiter;

    localparam int TMO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid, req_write, req_ready;
    logic [1:0][31:0]  req_addr;
    logic [1:0][3:0]   req_len;
    logic [1:0][31:0]  wdata;
    logic [1:0][3:0]   wstrb;
    logic [1:0]        wvalid, wready, rvalid, bdone;
    logic [31:0]       rdata;
    logic              rlast, err;
    logic [3:0]        m_arid, m_arlen, m_awid, m_awlen;
    logic [31:0]       m_araddr, m_awaddr, m_wdata, m_rdata;
    logic [2:0]        m_arsize, m_awsize;
    logic [1:0]        m_arburst, m_awburst;
    logic              m_arvalid, m_arready, m_awvalid, m_awready;
    logic [3:0]        m_wstrb;
    logic              m_wlast, m_wvalid, m_wready;
    logic              m_rlast, m_rvalid, m_rready, m_bvalid, m_bready;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_ar[$];
    logic [63:0] exp_aw[$];
    logic [63:0] exp_w[$];
    logic [63:0] exp_rd[$];
    logic [63:0] exp_bd[$];
    logic [63:0] exp_err[$];

    logic [63:0] outs_all;

    always #5 clk = ~clk;

    dram_req_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
        .req_ready(req_ready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .bdone(bdone), .err(err),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready),
        .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    assign outs_all = 64'({req_ready, wready, rvalid, bdone, err, rlast, m_rready, m_bready,
                           m_arvalid, m_awvalid, m_wvalid, m_wlast, m_arsize, m_awsize,
                           |rdata, |m_araddr, |m_awaddr, |m_wdata, |m_arburst, |m_awburst,
                           |m_arid, |m_awid, |m_arlen, |m_awlen, |m_wstrb});

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // All-ones marks "nothing expected"; real entries always carry zero padding.
    function automatic logic [63:0] take_exp(input int ch);
        logic [63:0] r;
        r = '1;
        case (ch)
            0: if (exp_ar.size() > 0)  r = exp_ar.pop_front();
            1: if (exp_aw.size() > 0)  r = exp_aw.pop_front();
            2: if (exp_w.size() > 0)   r = exp_w.pop_front();
            3: if (exp_rd.size() > 0)  r = exp_rd.pop_front();
            4: if (exp_bd.size() > 0)  r = exp_bd.pop_front();
            default: if (exp_err.size() > 0) r = exp_err.pop_front();
        endcase
        return r;
    endfunction

    function automatic logic [63:0] pk_addr(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len);
        return {19'b0, id, len, 3'd2, 2'b01, a};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (m_arvalid && m_arready)
                check_output("ar_hs", {19'b0, m_arid, m_arlen, m_arsize, m_arburst, m_araddr}, take_exp(0));
            if (m_awvalid && m_awready)
                check_output("aw_hs", {19'b0, m_awid, m_awlen, m_awsize, m_awburst, m_awaddr}, take_exp(1));
            if (m_wvalid && m_wready)
                check_output("w_beat", {25'b0, wready, m_wlast, m_wstrb, m_wdata}, take_exp(2));
            if (rvalid != 2'b00)
                check_output("r_beat", {29'b0, rvalid, rlast, rdata}, take_exp(3));
            if (bdone != 2'b00)
                check_output("bdone", {62'b0, bdone}, take_exp(4));
            if (err)
                check_output("err_pulse", 64'(err), take_exp(5));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [1:0] valid, input logic [1:0] write,
                                  input logic [1:0] exp_ready, input string name);
        req_valid = valid;
        req_write = write;
        @(negedge clk);
        check_output(name, 64'(req_ready), 64'(exp_ready));
        tick();
    endtask

    task automatic serve_addr(input logic wr, input logic [3:0] id, input logic [31:0] addr,
                              input logic [3:0] len, input int delay);
        if (wr) exp_aw.push_back(pk_addr(id, addr, len));
        else    exp_ar.push_back(pk_addr(id, addr, len));
        repeat (delay) begin
            @(negedge clk);
            check_output("addr_hold", wr ? 64'({m_awvalid, m_awaddr}) : 64'({m_arvalid, m_araddr}),
                         64'({1'b1, addr}));
            tick();
        end
        if (wr) m_awready = 1'b1;
        else    m_arready = 1'b1;
        tick();
        m_awready = 1'b0;
        m_arready = 1'b0;
    endtask

    task automatic serve_read(input logic idx, input logic [31:0] base, input logic [3:0] len,
                              input logic [3:0] rlast_at, input int gap_mod);
        for (int b = 0; b <= int'(rlast_at); b++) begin
            if (gap_mod != 0 && (b % gap_mod) == 1) begin
                m_rvalid = 1'b0;
                tick();
            end
            m_rvalid = 1'b1;
            m_rdata  = base + 32'(b);
            m_rlast  = (b == int'(rlast_at));
            exp_rd.push_back({29'b0, (idx ? 2'b10 : 2'b01), (b == int'(rlast_at)), base + 32'(b)});
            tick();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        if (rlast_at > len) $display("[TB] note: overrun read issued");
    endtask

    task automatic serve_write(input logic idx, input logic [31:0] base, input logic [3:0] len,
                               input logic [3:0] strb);
        for (int b = 0; b <= int'(len); b++) begin
            wvalid[idx] = 1'b1;
            wdata[idx]  = base + 32'(b);
            wstrb[idx]  = strb;
            m_wready    = 1'b1;
            exp_w.push_back({25'b0, (idx ? 2'b10 : 2'b01), (b == int'(len)), strb, base + 32'(b)});
            tick();
        end
        wvalid   = 2'b00;
        m_wready = 1'b0;
        m_bvalid = 1'b1;
        exp_bd.push_back({62'b0, (idx ? 2'b10 : 2'b01)});
        tick();
        m_bvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int waited;
        logic got;
        rst = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_len = '0;
        wdata = '0; wstrb = '0; wvalid = '0;
        m_arready = 0; m_awready = 0; m_wready = 0; m_rdata = '0; m_rlast = 0; m_rvalid = 0; m_bvalid = 0;
        #1 rst = 1'b0;
        req_valid = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_outputs", outs_all, 64'h0);
        req_valid = 2'b00;
        rst = 1'b1;
        tick();

        // Both requesters read in the same cycle: 0 first, then 1.
        req_addr[0] = 32'h0000_0100; req_len[0] = 4'd0;
        req_addr[1] = 32'h0000_0203; req_len[1] = 4'd0;
        apply_stimulus(2'b11, 2'b00, 2'b01, "grant_both_rd");
        req_valid = 2'b10;
        serve_addr(1'b0, 4'h0, 32'h0000_0100, 4'd0, 0);
        serve_read(1'b0, 32'hA000_0000, 4'd0, 4'd0, 0);
        apply_stimulus(2'b10, 2'b00, 2'b10, "grant_second_rd");
        req_valid = 2'b00;
        serve_addr(1'b0, 4'h1, 32'h0000_0200, 4'd0, 1);
        serve_read(1'b1, 32'hB000_0000, 4'd0, 4'd0, 0);

        // Requester 1 write burst of 4 with a slow address channel.
        req_addr[1] = 32'h0000_1004; req_len[1] = 4'd3;
        apply_stimulus(2'b10, 2'b10, 2'b10, "grant_wr1");
        req_valid = 2'b00;
        serve_addr(1'b1, 4'h1, 32'h0000_1004, 4'd3, 4);
        serve_write(1'b1, 32'hC0DE_0000, 4'd3, 4'b0101);

        // Sixteen-beat read with bubbles.
        req_addr[0] = 32'h0000_3000; req_len[0] = 4'd15;
        apply_stimulus(2'b01, 2'b00, 2'b01, "grant_rd16");
        req_valid = 2'b00;
        serve_addr(1'b0, 4'h0, 32'h0000_3000, 4'd15, 0);
        serve_read(1'b0, 32'h1000_0000, 4'd15, 4'd15, 3);

        // Write stalls on wvalid until the watchdog fires; requester 1 then wins.
        req_addr[0] = 32'h0000_0040; req_len[0] = 4'd1;
        apply_stimulus(2'b01, 2'b01, 2'b01, "grant_wr_stall");
        req_valid = 2'b00;
        serve_addr(1'b1, 4'h0, 32'h0000_0040, 4'd1, 0);
        m_wready = 1'b1;
        exp_err.push_back(64'h1);
        req_addr[1] = 32'h0000_0500; req_len[1] = 4'd0;
        req_write = 2'b00;
        req_valid = 2'b11;
        got = 1'b0;
        waited = -1;
        for (int i = 0; i < TMO + 10; i++) begin
            @(negedge clk);
            if (err) begin
                got = 1'b1;
                waited = i;
                break;
            end
        end
        check_output("timeout_seen", 64'(got), 64'h1);
        check_output("timeout_cycles", 64'(waited), 64'(TMO));
        check_output("rr_after_timeout", 64'({m_wvalid, req_ready}), 64'(3'b010));
        tick();
        req_valid = 2'b00;
        m_wready = 1'b0;
        serve_addr(1'b0, 4'h1, 32'h0000_0500, 4'd0, 0);
        serve_read(1'b1, 32'hD000_0000, 4'd0, 4'd0, 0);

        // Early rlast on a two-beat read raises err but still completes.
        req_addr[1] = 32'h0000_0600; req_len[1] = 4'd1;
        apply_stimulus(2'b10, 2'b00, 2'b10, "grant_rd_short");
        req_valid = 2'b00;
        exp_err.push_back(64'h1);
        serve_addr(1'b0, 4'h1, 32'h0000_0600, 4'd1, 0);
        serve_read(1'b1, 32'hE000_0000, 4'd1, 4'd0, 0);

        // Requester 0 served last, then reset mid-burst must restore priority to 0.
        req_addr[0] = 32'h0000_0700; req_len[0] = 4'd0;
        apply_stimulus(2'b01, 2'b00, 2'b01, "grant_rd0");
        req_valid = 2'b00;
        serve_addr(1'b0, 4'h0, 32'h0000_0700, 4'd0, 0);
        serve_read(1'b0, 32'hF000_0000, 4'd0, 4'd0, 0);
        req_addr[0] = 32'h0000_0800; req_len[0] = 4'd3;
        apply_stimulus(2'b01, 2'b00, 2'b01, "grant_rd_rst");
        req_valid = 2'b00;
        serve_addr(1'b0, 4'h0, 32'h0000_0800, 4'd3, 0);
        for (int b = 0; b < 2; b++) begin
            m_rvalid = 1'b1;
            m_rdata  = 32'h1111_0000 + 32'(b);
            m_rlast  = 1'b0;
            exp_rd.push_back({29'b0, 2'b01, 1'b0, 32'h1111_0000 + 32'(b)});
            tick();
        end
        m_rdata = 32'h1111_0002;
        rst = 1'b0;
        @(negedge clk);
        check_output("reset_mid_burst", outs_all, 64'h0);
        m_rvalid = 1'b0;
        req_addr[0] = 32'h0000_0900; req_len[0] = 4'd0;
        req_addr[1] = 32'h0000_0A00; req_len[1] = 4'd0;
        req_write = 2'b00;
        req_valid = 2'b11;
        tick();
        rst = 1'b1;
        apply_stimulus(2'b11, 2'b00, 2'b01, "rr_after_reset");
        req_valid = 2'b10;
        serve_addr(1'b0, 4'h0, 32'h0000_0900, 4'd0, 0);
        serve_read(1'b0, 32'h2222_0000, 4'd0, 4'd0, 0);
        apply_stimulus(2'b10, 2'b00, 2'b10, "grant_after_rst1");
        req_valid = 2'b00;
        serve_addr(1'b0, 4'h1, 32'h0000_0A00, 4'd0, 0);
        serve_read(1'b1, 32'h3333_0000, 4'd0, 4'd0, 0);

        repeat (3) tick();
        check_output("scoreboard_drained",
                     64'(exp_ar.size() + exp_aw.size() + exp_w.size() + exp_rd.size() +
                         exp_bd.size() + exp_err.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
